// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline-to-hazard-controller bundle. The master is the pipeline
// and the slave is pipe_ctrl.
interface pipe_ctrl_if;
  logic       ld_stall_i;
  logic       jump_i;
  logic       mdu_start_i;
  logic       mdu_done_i;
  logic       dmem_req_i;
  logic       dmem_ack_i;
  logic       pc_hold_o;
  logic       stall_if_o;
  logic       stall_id_o;
  logic       stall_ex_o;
  logic       stall_mem_o;
  logic       flush_id_o;
  logic       flush_ex_o;
  logic       bubble_ex_o;
  logic       bubble_mem_o;
  logic       bubble_wb_o;
  logic [1:0] state_o;
  logic       err_timeout_o;

  modport master (
    output ld_stall_i, jump_i, mdu_start_i, mdu_done_i, dmem_req_i, dmem_ack_i,
    input  pc_hold_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, bubble_ex_o, bubble_mem_o, bubble_wb_o,
           state_o, err_timeout_o
  );

  modport slave (
    input  ld_stall_i, jump_i, mdu_start_i, mdu_done_i, dmem_req_i, dmem_ack_i,
    output pc_hold_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, bubble_ex_o, bubble_mem_o, bubble_wb_o,
           state_o, err_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Mealy stall/flush/bubble controller with time-bounded memory and MDU waits.
// Optional stall/flush performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  // state      | meaning
  // S_RUN      | normal issue; hazards resolved combinationally
  // S_MEM_WAIT | MEM access outstanding, whole pipe frozen
  // S_MDU_WAIT | mul/div busy in EX, front end frozen
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_MDU_WAIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_err;
  logic       w_tmo_hit;
  logic       w_timeout;
  logic       w_mem_hold;
  logic       w_mdu_hold;
  logic       w_flush;
  logic       w_ld_hold;

  assign w_tmo_hit = (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_timeout;
      if (w_state_nxt == S_RUN || r_state == S_RUN) begin
        r_cnt <= '0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          w_state_nxt = S_MEM_WAIT;
        end else if (bus.mdu_start_i && !bus.mdu_done_i) begin
          w_state_nxt = S_MDU_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          w_state_nxt = S_RUN;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RUN;
          w_timeout   = 1'b1;
        end
      end
      S_MDU_WAIT: begin
        if (bus.mdu_done_i) begin
          w_state_nxt = S_RUN;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RUN;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Jump and load-use only matter in RUN; waits ignore them.
  always_comb begin
    w_mem_hold = 1'b0;
    w_mdu_hold = 1'b0;
    w_flush    = 1'b0;
    w_ld_hold  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          w_mem_hold = 1'b1;
        end else if (bus.mdu_start_i && !bus.mdu_done_i) begin
          w_mdu_hold = 1'b1;
        end else if (bus.jump_i) begin
          w_flush = 1'b1;
        end else if (bus.ld_stall_i) begin
          w_ld_hold = 1'b1;
        end
      end
      S_MEM_WAIT: w_mem_hold = !bus.dmem_ack_i && !w_tmo_hit;
      S_MDU_WAIT: w_mdu_hold = !bus.mdu_done_i && !w_tmo_hit;
      default: ;
    endcase
  end

  assign bus.pc_hold_o     = w_mem_hold | w_mdu_hold | w_ld_hold;
  assign bus.stall_if_o    = w_mem_hold | w_mdu_hold | w_ld_hold;
  assign bus.stall_id_o    = w_mem_hold | w_mdu_hold | w_ld_hold;
  assign bus.stall_ex_o    = w_mem_hold | w_mdu_hold;
  assign bus.stall_mem_o   = w_mem_hold;
  assign bus.flush_id_o    = w_flush;
  assign bus.flush_ex_o    = w_flush;
  assign bus.bubble_ex_o   = w_ld_hold;
  assign bus.bubble_mem_o  = w_mdu_hold;
  assign bus.bubble_wb_o   = w_mem_hold;
  assign bus.state_o       = r_state;
  // The sticky flag is visible already in the cycle the timeout fires.
  assign bus.err_timeout_o = r_err | w_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.pc_hold_o)  r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush_ex_o) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against an event-level model.
module tb_pipe_ctrl;
  localparam int T = 4;

  localparam int EV_NONE = 0;
  localparam int EV_MEM  = 1;
  localparam int EV_MDU  = 2;
  localparam int EV_JMP  = 3;
  localparam int EV_LU   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if ifc ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_ctrl #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // model: what we are waiting for (0 none, 1 memory, 2 mdu) and for how long
  int          m_wait;
  int          m_age;
  bit          m_err;
  int unsigned m_stall_ref;
  int unsigned m_flush_ref;

  logic [9:0] e_ctrl;
  logic [1:0] e_state;
  logic       e_err;
  int         e_next;
  bit         e_tmo;

  bit v_ld, v_j, v_st, v_dn, v_rq, v_ak;

  task automatic drive(input bit ld, input bit j, input bit st,
                       input bit dn, input bit rq, input bit ak);
    v_ld = ld; v_j = j; v_st = st; v_dn = dn; v_rq = rq; v_ak = ak;
    ifc.ld_stall_i  = ld;
    ifc.jump_i      = j;
    ifc.mdu_start_i = st;
    ifc.mdu_done_i  = dn;
    ifc.dmem_req_i  = rq;
    ifc.dmem_ack_i  = ak;
  endtask

  task automatic model_reset();
    m_wait = 0; m_age = 0; m_err = 1'b0;
    m_stall_ref = 0; m_flush_ref = 0;
  endtask

  task automatic predict();
    int  ev;
    bit  finished;
    ev     = EV_NONE;
    e_next = m_wait;
    e_tmo  = 1'b0;
    if (m_wait == 0) begin
      if (v_rq && !v_ak) begin ev = EV_MEM; e_next = 1; end
      else if (v_st && !v_dn) begin ev = EV_MDU; e_next = 2; end
      else if (v_j) ev = EV_JMP;
      else if (v_ld) ev = EV_LU;
    end else begin
      finished = (m_wait == 1) ? v_ak : v_dn;
      if (finished) e_next = 0;
      else if (m_age == T - 1) begin e_next = 0; e_tmo = 1'b1; end
      else ev = (m_wait == 1) ? EV_MEM : EV_MDU;
    end
    // {pc_hold, stall_if/id/ex/mem, flush_id/ex, bubble_ex/mem/wb}
    case (ev)
      EV_MEM:  e_ctrl = 10'b11111_00_001;
      EV_MDU:  e_ctrl = 10'b11110_00_010;
      EV_JMP:  e_ctrl = 10'b00000_11_000;
      EV_LU:   e_ctrl = 10'b11100_00_100;
      default: e_ctrl = 10'b00000_00_000;
    endcase
    e_state = 2'(m_wait);
    e_err   = m_err | e_tmo;
  endtask

  task automatic advance();
    if (e_ctrl[9]) m_stall_ref++;
    if (e_ctrl[3]) m_flush_ref++;
    if (e_next == 0)      m_age = 0;
    else if (m_wait == 0) m_age = 0;
    else if (m_age < 255) m_age = m_age + 1;
    m_err  = m_err | e_tmo;
    m_wait = e_next;
  endtask

  task automatic check(input string tag);
    logic [9:0] got;
    got = {ifc.pc_hold_o, ifc.stall_if_o, ifc.stall_id_o, ifc.stall_ex_o, ifc.stall_mem_o,
           ifc.flush_id_o, ifc.flush_ex_o, ifc.bubble_ex_o, ifc.bubble_mem_o, ifc.bubble_wb_o};
    total++;
    assert (got === e_ctrl) else begin
      bad++; $error("FAIL %s ctrl got=%b exp=%b", tag, got, e_ctrl);
    end
    total++;
    assert (ifc.state_o === e_state) else begin
      bad++; $error("FAIL %s state got=%0d exp=%0d", tag, ifc.state_o, e_state);
    end
    total++;
    assert (ifc.err_timeout_o === e_err) else begin
      bad++; $error("FAIL %s err got=%b exp=%b", tag, ifc.err_timeout_o, e_err);
    end
  endtask

  // Called 1 time unit after a rising edge: check at the falling edge, then clock.
  task automatic step(input string tag);
    predict();
    @(negedge clk);
    check(tag);
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    predict();
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    advance();
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    predict();
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1, 0, 0, 0, 0, 0); step("load_use");
    drive(0, 0, 0, 0, 0, 0); step("load_use_off");
    drive(1, 1, 0, 0, 0, 0); step("jump_vs_lu");
    drive(0, 0, 0, 0, 0, 0); step("idle1");

    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("mem_wait");
    drive(0, 0, 0, 0, 1, 1); step("mem_ack");
    drive(0, 0, 0, 0, 0, 0); step("idle2");

    drive(0, 0, 1, 0, 1, 0); step("mem_beats_mdu");
    drive(0, 1, 1, 0, 1, 1); step("mem_ack_mdu_pending");
    drive(0, 0, 1, 0, 0, 0); step("mdu_enter");
    drive(1, 1, 1, 0, 1, 0); step("mdu_ignores");
    drive(0, 0, 1, 1, 0, 0); step("mdu_done");
    drive(0, 0, 1, 1, 0, 0); step("mdu_same_cycle");
    drive(0, 0, 0, 0, 0, 0); step("idle3");

    drive(0, 0, 1, 0, 0, 0); step("mdu_rst_enter");
    step("mdu_rst_wait");
    drive(0, 0, 0, 0, 0, 0);
    #2;
    predict();
    check("pre_async_rst");
    async_reset("async_rst_mdu");

    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("timeout_seq");
    drive(0, 0, 0, 0, 0, 0); step("after_timeout");
    step("err_sticky");
    async_reset("err_clear");

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if (i % 100 == 99) async_reset("rand_rst");
      else step("random");
    end

`ifdef PIPE_PERF_CNT_EN
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    assert (stall_cnt === m_stall_ref) else begin
      bad++; $error("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, m_stall_ref);
    end
    total++;
    assert (flush_cnt === m_flush_ref) else begin
      bad++; $error("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, m_flush_ref);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
